sig_cic: RTL and testbench
==========================

Name: sig_cic

Overview:
- Single-stage CIC (cascaded integrator-comb) decimation filter with decimation ratio 8 and differential delay 1.
- Accepts one signed 10-bit sample per clock and emits one signed 13-bit full-precision decimated sample every 8 clocks, flagged by a one-cycle `rdy` strobe.
- Sits directly after the signal source or ADC capture, ahead of downstream compensation and FIR stages.

Parameters:
- DIN_W, 10, input sample width (signed two's complement).
- R, 8, decimation ratio; must be a power of 2 and at least 2.
- DOUT_W, 13, output width; must equal DIN_W + log2(R), the full CIC bit growth for N=1, M=1.

Ports:
- clk  in  1  system clock; one input sample is consumed on every rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- din  in  DIN_W  signed input sample.
- dout  out  DOUT_W  signed decimated output; holds its value between strobes.
- rdy  out  1  one-cycle high pulse when dout has been updated with a new value.

Behaviour:
- Reset (rst=0 at a clk edge) clears the integrator register, comb delay register, phase counter, dout and rdy to 0. Reset overrides all other activity, including mid-window: the partial window is discarded.
- Integrator:
  - Each non-reset edge: acc <= acc + sext(din) in DOUT_W bits, wrapping modulo 2^DOUT_W.
  - Wrap is intentional and harmless. The result is exact because DOUT_W covers the full bit growth.
- Phase counter:
  - Runs 0..R-1, increments every non-reset edge, and wraps R-1 -> 0.
  - The first edge after reset release sees cnt=0.
- Decimation and comb, at an edge where cnt==R-1:
  - Let acc_n = acc + sext(din), the integrator's new value.
  - dout <= acc_n - comb_d (modulo 2^DOUT_W).
  - comb_d <= acc_n.
  - rdy <= 1.
- All other edges: rdy <= 0; dout and comb_d hold.
- Result: dout equals the exact sum of the R most recent samples, including the sample present on the strobe edge. Range is -4096..+4088 for the defaults, so it never saturates.
- Timing:
  - First rdy is asserted after the 8th clock edge following reset release (samples 1..8 summed).
  - Subsequent rdy pulses occur every R clocks.
  - Latency: dout is valid on the same edge that registers the last window sample; no extra pipeline stages.
- No input handshake: din is treated as valid every clock. No backpressure.
- Reset asserted on the same edge as a strobe: reset wins, rdy=0, dout=0.
- DC gain is R (no output scaling or truncation). Any gain normalisation is downstream's responsibility.

Decomposition:
- Shared package sig_cic_pkg holds DIN_W, R and DOUT_W defaults, plus a localparam for log2(R) (counter width).
- One natural sub-module, cic_integrator: a sign-extending wrapping accumulator with synchronous active-low clear.
- Comb, counter and output registers live in the top module sig_cic.

Test Plan:
- DC +1: reset low 3 cycles, then din=1 constant -> first rdy on the 8th edge after release with dout=8; every subsequent rdy (period 8) gives dout=8.
- Full-scale extremes: din=511 constant -> dout=4088; din=-512 constant -> dout=-4096. Both must hold across >100 windows, exercising integrator wrap with no error.
- Impulse: din=100 on the window's 3rd sample, 0 elsewhere -> dout=100 for that window and 0 for following windows. rdy is high exactly 1 cycle in 8.
- Alternating +300/-300 (even count per window) -> dout=0 every strobe. Ramp 1,2,...,8 -> dout=36, then 9..16 -> 100.
- Mid-window reset: apply din=5 for 5 cycles, assert rst=0 for 1 cycle, then din=5 -> dout=0 and rdy=0 during reset; next rdy comes 8 edges after release with dout=40.
- Reference compare: 4096-sample random din in [-512,511] -> every dout equals the software sum of the corresponding 8-sample block; rdy count = 512.

Source files
------------

// File: rtl/sig_cic_pkg.sv
// sig_cic_pkg: shared defaults for the single-stage CIC decimator
package sig_cic_pkg;
   localparam int DIN_W_DEF  = 10;
   localparam int R_DEF      = 8;
   localparam int LOG2R_DEF  = $clog2(R_DEF);
   localparam int DOUT_W_DEF = DIN_W_DEF + LOG2R_DEF;
endpackage

// File: rtl/cic_integrator.sv
// cic_integrator: sign-extending wrapping accumulator with sync active-low clear
module cic_integrator
   import sig_cic_pkg::*;
#(
   parameter int IN_W  = DIN_W_DEF,
   parameter int ACC_W = DOUT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [IN_W-1:0]  din,
   output logic signed [ACC_W-1:0] acc_n
);
   logic signed [ACC_W-1:0] acc_q;
   // next accumulator value; modulo wrap is exact given full bit growth
   always_comb acc_n = acc_q + {{(ACC_W-IN_W){din[IN_W-1]}}, din};
   // accumulate every clock, cleared by reset
   always_ff @(posedge clk)
      acc_q <= !rst ? '0 : acc_n;
endmodule

// File: rtl/sig_cic.sv
// sig_cic: single-stage CIC decimator (N=1, M=1) with full-precision output
module sig_cic
   import sig_cic_pkg::*;
#(
   parameter int DIN_W  = DIN_W_DEF,
   parameter int R      = R_DEF,
   parameter int DOUT_W = DOUT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DIN_W-1:0]  din,
   output logic signed [DOUT_W-1:0] dout,
   output logic                     rdy
);
   localparam int CNT_W = $clog2(R);
   logic [CNT_W-1:0]         cnt_d, cnt_q;
   logic signed [DOUT_W-1:0] acc_n, comb_d, comb_q, dout_d, dout_q;
   logic                     rdy_d, rdy_q, strobe;
   cic_integrator #(.IN_W(DIN_W), .ACC_W(DOUT_W)) u_int (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .acc_n(acc_n)
   );
   // phase counter wraps naturally at R; comb fires on the last phase of each window
   always_comb begin
      strobe = cnt_q == CNT_W'(R - 1);
      cnt_d  = cnt_q + CNT_W'(1);
      dout_d = strobe ? acc_n - comb_q : dout_q;
      comb_d = strobe ? acc_n : comb_q;
      rdy_d  = strobe;
   end
   // state registers; reset discards any partial window
   always_ff @(posedge clk) begin
      cnt_q  <= !rst ? '0 : cnt_d;
      comb_q <= !rst ? '0 : comb_d;
      dout_q <= !rst ? '0 : dout_d;
      rdy_q  <= !rst ? 1'b0 : rdy_d;
   end
   assign dout = dout_q;
   assign rdy  = rdy_q;
endmodule

// File: tb/tb_sig_cic.sv
// tb_sig_cic: directed + random scoreboard bench for the CIC decimator
module tb_sig_cic;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  din = '0;
   logic [12:0] dout;
   logic        rdy;
   int          errors = 0;
   int          checks = 0;
   int          mcnt = 0;
   int          msum = 0;
   int          rdy_cnt = 0;
   logic        exp_rdy;
   logic [12:0] last_dout = '0;
   logic [12:0] q[$];

   sig_cic dut (.clk(clk), .rst(rst), .din(din), .dout(dout), .rdy(rdy));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      din = 10'($urandom);
      @(posedge clk); #1;
      mcnt = 0; msum = 0; q.delete(); last_dout = '0;
      chk("rst_rdy", 16'(rdy), 16'(1'b0));
      chk("rst_dout", 16'(dout), 16'(13'd0));
   endtask

   task automatic step(input int v);
      rst = 1'b1;
      din = 10'(v);
      msum += v;
      exp_rdy = (mcnt == 7);
      if (exp_rdy) begin
         q.push_back(13'(msum));
         msum = 0;
      end
      mcnt = (mcnt + 1) % 8;
      @(posedge clk); #1;
      chk("rdy", 16'(rdy), 16'(exp_rdy));
      if (rdy === 1'b1) begin
         rdy_cnt++;
         last_dout = (q.size() > 0) ? q.pop_front() : 13'bx;
      end
      chk("dout", 16'(dout), 16'(last_dout));
   endtask

   initial begin
      repeat (3) do_reset();
      // DC +1
      repeat (32) step(1);
      chk("dc1_val", 16'(dout), 16'(13'd8));
      // full-scale positive and negative, >100 windows each
      repeat (8 * 110) step(511);
      chk("pos_fs", 16'(dout), 16'(13'd4088));
      repeat (8 * 110) step(-512);
      chk("neg_fs", 16'(dout), 16'(13'h1000));
      // impulse on the third sample of a window
      for (int i = 0; i < 8; i++) step(i == 2 ? 100 : 0);
      chk("impulse", 16'(dout), 16'(13'd100));
      repeat (16) step(0);
      chk("impulse_after", 16'(dout), 16'(13'd0));
      // alternating +/-300
      for (int i = 0; i < 32; i++) step(i % 2 ? -300 : 300);
      chk("alt", 16'(dout), 16'(13'd0));
      // ramp
      for (int i = 1; i <= 8; i++) step(i);
      chk("ramp1", 16'(dout), 16'(13'd36));
      for (int i = 9; i <= 16; i++) step(i);
      chk("ramp2", 16'(dout), 16'(13'd100));
      // mid-window reset
      repeat (5) step(5);
      do_reset();
      repeat (8) step(5);
      chk("midrst", 16'(dout), 16'(13'd40));
      // random reference compare
      rdy_cnt = 0;
      for (int i = 0; i < 4096; i++) step(int'($urandom_range(1023)) - 512);
      chk("rdy_count", 16'(rdy_cnt), 16'(512));
      chk("q_drained", 16'(q.size()), 16'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
